// File: rtl/jogo_pkg.sv
// Shared state encoding and board-size helpers for the move controller.
package jogo_pkg;

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      PREPARA      = 4'd1,
      ESPERA_MACRO = 4'd2,
      ESPERA_MICRO = 4'd3,
      VALIDA       = 4'd4,
      ESCREVE      = 4'd5,
      TROCA        = 4'd6,
      FIM          = 4'd7
   } estado_t;

   function automatic int celulas(input int n);
      return n * n;
   endfunction

   // A 1x1 board still needs a 1-bit index field.
   function automatic int largura_indice(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

endpackage

// File: rtl/controlador_jogada_if.sv
// Board-side bundle of the move controller: button/board status in, selection and status out.
interface controlador_jogada_if #(
   parameter int N    = 3,
   parameter int ERRW = 8
);
   import jogo_pkg::*;

   localparam int CELLS = celulas(N);
   localparam int IDXW  = largura_indice(N);

   logic             iniciar;
   logic [CELLS-1:0] botoes;
   logic [CELLS-1:0] macro_fechada;
   logic [CELLS-1:0] micro_ocupada;
   logic             fim_jogo;

   logic [IDXW-1:0]  macro_atual;
   logic [IDXW-1:0]  micro_atual;
   logic             jogador;
   logic             jogada_valida;
   logic             timeout;
   logic             jogar_macro;
   logic             jogar_micro;
   logic             pronto;
   logic [ERRW-1:0]  erros;
   logic [3:0]       db_estado;

   modport slave (
      input  iniciar, botoes, macro_fechada, micro_ocupada, fim_jogo,
      output macro_atual, micro_atual, jogador, jogada_valida, timeout,
             jogar_macro, jogar_micro, pronto, erros, db_estado
   );

   modport master (
      output iniciar, botoes, macro_fechada, micro_ocupada, fim_jogo,
      input  macro_atual, micro_atual, jogador, jogada_valida, timeout,
             jogar_macro, jogar_micro, pronto, erros, db_estado
   );

endinterface

// File: rtl/contador_timeout.sv
// Per-move timer: fim pulses on the TIMEOUT-th cycle counted since the last clear,
// and the counter restarts from zero on that same edge.
module contador_timeout #(
   parameter int TIMEOUT = 5000
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   assign fim = conta && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt <= '0;
      end else if (zera || fim) begin
         cnt <= '0;
      end else if (conta) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/controlador_jogada.sv
// Ultimate tic-tac-toe move controller: macro/micro selection, validation, board write strobe,
// per-move timeout and rejected-press counting. Press-to-strobe latency is 2 cycles.
module controlador_jogada
   import jogo_pkg::*;
#(
   parameter int N       = 3,
   parameter int TIMEOUT = 5000,
   parameter int ERRW    = 8
) (
   input logic                 clock,
   input logic                 reset,
   controlador_jogada_if.slave bus
);

   localparam int CELLS = celulas(N);
   localparam int IDXW  = largura_indice(N);

   estado_t          estado, prox_estado;
   logic [IDXW-1:0]  macro_q, macro_d;
   logic [IDXW-1:0]  micro_q, micro_d;
   logic             jogador_q, jogador_d;
   logic [ERRW-1:0]  erros_q, erros_d;
   logic [CELLS-1:0] botoes_q;
   logic [CELLS-1:0] press;
   logic             press_valida, press_multipla;
   logic [IDXW-1:0]  k;
   logic             erro, limpa_erros;
   logic             zera, conta, fim;

   function automatic logic [IDXW-1:0] codifica(input logic [CELLS-1:0] v);
      logic [IDXW-1:0] r;
      r = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (v[i]) r = r | IDXW'(i);
      end
      return r;
   endfunction

   // Rising edges only; anything other than a single new button is a rejected press.
   assign press          = bus.botoes & ~botoes_q;
   assign press_valida   = $onehot(press);
   assign press_multipla = (press != '0) && !press_valida;
   assign k              = codifica(press);

   assign conta = (estado == ESPERA_MACRO) || (estado == ESPERA_MICRO) || (estado == VALIDA);
   assign zera  = (estado == PREPARA) || (estado == TROCA);

   contador_timeout #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock (clock),
      .reset (reset),
      .zera  (zera),
      .conta (conta),
      .fim   (fim)
   );

   always_comb begin
      prox_estado = estado;
      macro_d     = macro_q;
      micro_d     = micro_q;
      jogador_d   = jogador_q;
      erro        = 1'b0;
      limpa_erros = 1'b0;
      case (estado)
         INICIAL: begin
            if (bus.iniciar) prox_estado = PREPARA;
         end
         PREPARA: begin
            jogador_d   = 1'b0;
            limpa_erros = 1'b1;
            prox_estado = ESPERA_MACRO;
         end
         // Expiry wins over any press seen in the same cycle.
         ESPERA_MACRO: begin
            if (fim) begin
               jogador_d = ~jogador_q;
            end else if (press_multipla) begin
               erro = 1'b1;
            end else if (press_valida) begin
               if (bus.macro_fechada[k]) begin
                  erro = 1'b1;
               end else begin
                  macro_d     = k;
                  prox_estado = ESPERA_MICRO;
               end
            end
         end
         ESPERA_MICRO: begin
            if (fim) begin
               jogador_d   = ~jogador_q;
               prox_estado = ESPERA_MACRO;
            end else if (press_multipla) begin
               erro = 1'b1;
            end else if (press_valida) begin
               micro_d     = k;
               prox_estado = VALIDA;
            end
         end
         VALIDA: begin
            if (fim) begin
               jogador_d   = ~jogador_q;
               prox_estado = ESPERA_MACRO;
            end else if (bus.micro_ocupada[micro_q]) begin
               erro        = 1'b1;
               prox_estado = ESPERA_MICRO;
            end else begin
               prox_estado = ESCREVE;
            end
         end
         ESCREVE: begin
            prox_estado = TROCA;
         end
         // Board status reflects the write from ESCREVE by now.
         TROCA: begin
            jogador_d = ~jogador_q;
            if (bus.fim_jogo) begin
               prox_estado = FIM;
            end else if (bus.macro_fechada[micro_q]) begin
               prox_estado = ESPERA_MACRO;
            end else begin
               macro_d     = micro_q;
               prox_estado = ESPERA_MICRO;
            end
         end
         FIM: begin
            if (bus.iniciar) prox_estado = PREPARA;
         end
         default: prox_estado = INICIAL;
      endcase

      if (limpa_erros) begin
         erros_d = '0;
      end else if (erro && (erros_q != '1)) begin
         erros_d = erros_q + 1'b1;
      end else begin
         erros_d = erros_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado    <= INICIAL;
         macro_q   <= '0;
         micro_q   <= '0;
         jogador_q <= 1'b0;
         erros_q   <= '0;
         botoes_q  <= '0;
      end else begin
         estado    <= prox_estado;
         macro_q   <= macro_d;
         micro_q   <= micro_d;
         jogador_q <= jogador_d;
         erros_q   <= erros_d;
         botoes_q  <= bus.botoes;
      end
   end

   assign bus.macro_atual   = macro_q;
   assign bus.micro_atual   = micro_q;
   assign bus.jogador       = jogador_q;
   assign bus.erros         = erros_q;
   assign bus.jogada_valida = (estado == ESCREVE);
   assign bus.timeout       = fim;
   assign bus.jogar_macro   = (estado == ESPERA_MACRO);
   assign bus.jogar_micro   = (estado == ESPERA_MICRO);
   assign bus.pronto        = (estado == FIM);
   assign bus.db_estado     = estado;

endmodule
